// File: rtl/reg_status_file.sv
// Architectural register file with rename/busy table, written back by the ROB commit bus.
// Optional same-cycle commit-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_status_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              rename_valid,
    input  logic [REG_AW-1:0] rename_reg,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              commit_valid,
    input  logic [REG_AW-1:0] commit_reg,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_data
);

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];
    logic              busy_q [REG_NUM];

    logic commit_en;
    logic rename_en;

    assign commit_en = rdy && commit_valid && (commit_reg != '0);
    assign rename_en = rdy && !clear && rename_valid && (rename_reg != '0);

    // Later non-blocking writes win: clear/rename override the commit release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                data_q[REG_AW'(i)] <= '0;
                tag_q[REG_AW'(i)]  <= '0;
                busy_q[REG_AW'(i)] <= 1'b0;
            end
        end else if (rdy) begin
            if (commit_en) begin
                data_q[commit_reg] <= commit_data;
                if (busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag)) begin
                    busy_q[commit_reg] <= 1'b0;
                end
            end
            if (clear) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    busy_q[REG_AW'(i)] <= 1'b0;
                end
            end else if (rename_en) begin
                busy_q[rename_reg] <= 1'b1;
                tag_q[rename_reg]  <= rename_tag;
            end
        end
    end

    // Source 1 read port; x0 always reads as idle zero.
    always_comb begin
        rs1_busy = 1'b0;
        rs1_tag  = '0;
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_busy = busy_q[rs1_addr];
            rs1_tag  = tag_q[rs1_addr];
            rs1_data = data_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (commit_valid && (commit_reg == rs1_addr) && busy_q[rs1_addr]
                && (tag_q[rs1_addr] == commit_tag)) begin
                rs1_busy = 1'b0;
                rs1_data = commit_data;
            end
`endif
        end
    end

    // Source 2 read port.
    always_comb begin
        rs2_busy = 1'b0;
        rs2_tag  = '0;
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_busy = busy_q[rs2_addr];
            rs2_tag  = tag_q[rs2_addr];
            rs2_data = data_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (commit_valid && (commit_reg == rs2_addr) && busy_q[rs2_addr]
                && (tag_q[rs2_addr] == commit_tag)) begin
                rs2_busy = 1'b0;
                rs2_data = commit_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: expected read results are queued when a step is
// driven and popped/compared against the read ports once the step's outputs are settled.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        rename_valid;
    logic [4:0]  rename_reg;
    logic [3:0]  rename_tag;
    logic [4:0]  rs1_addr;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic [31:0] rs2_data;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;

    typedef struct packed {
        logic        port;
        logic        busy;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    reg_status_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .rename_valid(rename_valid), .rename_reg(rename_reg), .rename_tag(rename_tag),
        .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_data(rs2_data),
        .commit_valid(commit_valid), .commit_reg(commit_reg),
        .commit_tag(commit_tag), .commit_data(commit_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rename_valid = 1'b0;
        commit_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic expect_rd(input string nm, input logic port, input logic b,
                             input logic [3:0] t, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.busy = b;
        e.tag  = t;
        e.data = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Settle, then pop every queued expectation and compare against the chosen port.
    task automatic check_now();
        exp_t  e;
        string nm;
        logic        ob;
        logic [3:0]  ot;
        logic [31:0] od;
        #1;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ob = e.port ? rs2_busy : rs1_busy;
            ot = e.port ? rs2_tag  : rs1_tag;
            od = e.port ? rs2_data : rs1_data;
            tests++;
            assert (ob === e.busy) else begin
                fails++;
                $error("FAIL %s busy observed=%0h expected=%0h", nm, ob, e.busy);
            end
            tests++;
            assert (ot === e.tag) else begin
                fails++;
                $error("FAIL %s tag observed=%0h expected=%0h", nm, ot, e.tag);
            end
            tests++;
            assert (od === e.data) else begin
                fails++;
                $error("FAIL %s data observed=%0h expected=%0h", nm, od, e.data);
            end
        end
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [3:0] t);
        rename_valid = 1'b1;
        rename_reg   = r;
        rename_tag   = t;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        commit_valid = 1'b1;
        commit_reg   = r;
        commit_tag   = t;
        commit_data  = d;
    endtask

    initial begin
        logic [31:0] dvals [8];
        dvals = '{32'h0, 32'h55, 32'hDEAD, 32'h9, 32'h0, 32'h11, 32'h0, 32'h0};

        rst = 1'b1; rdy = 1'b1; idle();
        rename_reg = '0; rename_tag = '0;
        commit_reg = '0; commit_tag = '0; commit_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and x0 immunity
        rs1_addr = 5'd5;
        expect_rd("reset_x5", 1'b0, 1'b0, 4'd0, 32'd0);
        check_now();
        do_rename(5'd0, 4'd9);
        tick(); idle();
        rs1_addr = 5'd0;
        expect_rd("x0_after_rename", 1'b0, 1'b0, 4'd0, 32'd0);
        check_now();

        // Rename then matching commit
        do_rename(5'd3, 4'd2);
        tick(); idle();
        rs1_addr = 5'd3;
        expect_rd("x3_renamed", 1'b0, 1'b1, 4'd2, 32'd0);
        check_now();
        do_commit(5'd3, 4'd2, 32'hDEAD);
        tick(); idle();
        expect_rd("x3_committed", 1'b0, 1'b0, 4'd2, 32'hDEAD);
        check_now();

        // Stale commit keeps the younger mapping
        do_rename(5'd4, 4'd1); tick();
        do_rename(5'd4, 4'd5); tick(); idle();
        do_commit(5'd4, 4'd1, 32'd7);
        tick(); idle();
        rs1_addr = 5'd4;
        expect_rd("x4_stale_commit", 1'b0, 1'b1, 4'd5, 32'd7);
        check_now();
        do_commit(5'd4, 4'd5, 32'd9);
        tick(); idle();
        expect_rd("x4_final_commit", 1'b0, 1'b0, 4'd5, 32'd9);
        check_now();

        // Same-cycle rename and commit to the same register
        do_rename(5'd6, 4'd2);
        tick(); idle();
        do_rename(5'd6, 4'd3);
        do_commit(5'd6, 4'd2, 32'h11);
        rs1_addr = 5'd6;
`ifdef REGFILE_BYPASS_EN
        expect_rd("x6_pre_edge", 1'b0, 1'b0, 4'd2, 32'h11);
`else
        expect_rd("x6_pre_edge", 1'b0, 1'b1, 4'd2, 32'd0);
`endif
        check_now();
        tick(); idle();
        expect_rd("x6_rename_wins", 1'b0, 1'b1, 4'd3, 32'h11);
        check_now();

        // Clear with concurrent commit and dropped rename
        for (int i = 1; i <= 8; i++) begin
            do_rename(5'(i), 4'(i));
            tick();
        end
        idle();
        clear = 1'b1;
        do_commit(5'd2, 4'd2, 32'h55);
        do_rename(5'd9, 4'd7);
        tick(); idle();
        for (int i = 1; i <= 8; i++) begin
            rs1_addr = 5'(i);
            expect_rd($sformatf("clear_x%0d", i), 1'b0, 1'b0, 4'(i), dvals[i-1]);
            check_now();
        end
        rs2_addr = 5'd9;
        expect_rd("clear_drops_rename", 1'b1, 1'b0, 4'd0, 32'd0);
        check_now();

        // Commit forwarding behaviour on rs2
        do_rename(5'd7, 4'd4);
        tick(); idle();
        rs2_addr = 5'd7;
        expect_rd("x7_renamed", 1'b1, 1'b1, 4'd4, 32'd0);
        check_now();
        do_commit(5'd7, 4'd4, 32'hAB);
`ifdef REGFILE_BYPASS_EN
        expect_rd("x7_same_cycle", 1'b1, 1'b0, 4'd4, 32'hAB);
`else
        expect_rd("x7_same_cycle", 1'b1, 1'b1, 4'd4, 32'd0);
`endif
        check_now();
        tick(); idle();
        expect_rd("x7_next_cycle", 1'b1, 1'b0, 4'd4, 32'hAB);
        check_now();

        // rdy low freezes all state
        rdy = 1'b0;
        do_rename(5'd10, 4'd6);
        do_commit(5'd2, 4'd2, 32'h99);
        clear = 1'b1;
        tick(); tick(); tick();
        idle();
        rdy = 1'b1;
        rs1_addr = 5'd10;
        rs2_addr = 5'd2;
        expect_rd("hold_x10", 1'b0, 1'b0, 4'd0, 32'd0);
        expect_rd("hold_x2", 1'b1, 1'b0, 4'd2, 32'h55);
        check_now();
        rs1_addr = 5'd4;
        expect_rd("hold_x4", 1'b0, 1'b0, 4'd4, 32'd9);
        check_now();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
